kbd_matrix_gen: RTL and testbench
=================================

KBD_MATRIX_GEN -- requirements
Module: kbd_matrix_gen

Interface
REQ-001 Parameter ROWS, default 8: number of matrix rows; legal range 1..8.
REQ-002 Parameter COLS, default 8: number of matrix columns; legal range 1..8.
REQ-003 Parameter INJ_HOLD, default 40000: clock cycles per injected-key press phase and per release gap; legal range 1..65535.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scancode; bit 8 set means E0-extended.
REQ-007 row  in  ROWS  row select, active-low; multiple rows may be low at once.
REQ-008 kbus  out  COLS  column readback, active-low.
REQ-009 map_we  in  1  keymap write strobe.
REQ-010 map_addr  in  9  keymap write address (scancode).
REQ-011 map_data  in  8  keymap entry: [7] valid, [5:3] row index, [2:0] column index; [6] ignored.
REQ-012 inj_valid  in  1  injection request.
REQ-013 inj_pos  in  6  injected position: [5:3] row, [2:0] column.
REQ-014 inj_ready  out  1  injection port can accept a request.

Function
REQ-015 Keymap: 512x8 RAM, written in the cycle map_we=1; power-up contents all-invalid (bit 7 = 0).
REQ-016 Event detect: ps2_key[10] is registered twice; an event is taken in the cycle the two registered copies differ (edge E0).
REQ-017 Pipeline: E0 latches pressed and scancode and issues the keymap read; E1 updates per-position state; E2 registers kbus; key state is visible on kbus at E2 or earlier.
REQ-018 Simultaneous map write and lookup of the same address: the lookup returns the pre-write entry.
REQ-019 Scancode bitmap (512 bits): a make for a scancode already down, or a break for a scancode already up, is discarded with no counter change (suppresses typematic repeats).
REQ-020 Per-position 2-bit press counter: an accepted make increments it, saturating at 3; an accepted break decrements it, flooring at 0; the position is down while its count is non-zero.
REQ-021 Events whose keymap entry is invalid, or whose row index >= ROWS or column index >= COLS, update the bitmap only.
REQ-022 Injection FSM states: IDLE -> PRESS on inj_valid & inj_ready; PRESS -> GAP after INJ_HOLD cycles; GAP -> IDLE after INJ_HOLD cycles.
REQ-023 inj_ready = 1 only in IDLE; inj_valid outside IDLE is ignored.
REQ-024 inj_pos is captured on acceptance; the captured position is down throughout PRESS, OR-ed with counter state.
REQ-025 An out-of-range inj_pos is accepted and times normally but asserts no position.
REQ-026 Hold counter: 16-bit, loaded at each state entry.
REQ-027 Output: kbus[c] is registered 0 iff some r has row[r]=0 and position (r,c) down; otherwise 1; one-cycle latency from row to kbus.

Reset
REQ-028 Reset clears: all counters; the scancode bitmap; the event-detect registers, loaded with the current ps2_key[10] so no spurious event follows; the pipeline; FSM to IDLE; kbus to all-ones.
REQ-029 Reset leaves keymap RAM contents unchanged.
REQ-030 Reset takes priority over events, map writes and injection in the same cycle, including mid-PRESS (the injected key releases immediately).

Verification
REQ-031 Map scancode 0x01C to row 1, col 2 (map_data=0x8A); make 0x01C; hold row=0xFD -> kbus=0xFB within 3 cycles of the toggle; break -> kbus=0xFF.
REQ-032 Map 0x012 and 0x059 both to 0x8F; make both, break 0x012 -> bit 7 still low on row 1; break 0x059 -> kbus=0xFF.
REQ-033 Send make 0x01C three times, then one break -> position released (repeats discarded).
REQ-034 INJ_HOLD=4, inj_pos=6'o17 with row=0xFD -> inj_ready drops the next cycle; kbus=0x7F for 4 cycles, then 0xFF; inj_ready returns after 4 more cycles.
REQ-035 Assert reset mid-PRESS with counter-held keys -> kbus=0xFF the cycle after reset; an earlier map entry still works after reset.
REQ-036 map_we to 0x01C in the same cycle as its lookup: the old entry is applied to this event and the new entry to the next event.

Source files
------------

// File: rtl/kbd_matrix_gen.sv
// PS/2 key events and timed injections drive an emulated ROWSxCOLS keyboard matrix.
// Events reach kbus three cycles after the toggle is registered; row->kbus is one cycle; inj_ready is low while busy.
module kbd_matrix_gen #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int INJ_HOLD = 40000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     ps2_key,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] kbus,
    input  logic            map_we,
    input  logic [8:0]      map_addr,
    input  logic [7:0]      map_data,
    input  logic            inj_valid,
    input  logic [5:0]      inj_pos,
    output logic            inj_ready
);
    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} inj_state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(INJ_HOLD - 1);

    logic [7:0]      keymap [512];
    logic [7:0]      map_rd;
    logic            tog_q1, tog_q2, evt;
    logic            e1_vld, e1_press, e1_take, e1_hit;
    logic [8:0]      e1_code;
    logic [511:0]    key_bmp;
    logic [1:0]      cnt [ROWS][COLS];
    inj_state_t      state, state_nxt;
    logic [15:0]     hold, hold_nxt;
    logic [5:0]      inj_pos_q;
    logic            inj_on;
    logic [COLS-1:0] kbus_nxt;
    logic            unused_map_bit;

    assign unused_map_bit = map_rd[6];

    // Registered read ahead of the write gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (map_we && !reset)
            keymap[map_addr] <= map_data;
        map_rd <= keymap[ps2_key[8:0]];
    end

    assign evt = tog_q1 ^ tog_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q1   <= ps2_key[10];
            tog_q2   <= ps2_key[10];
            e1_vld   <= 1'b0;
            e1_press <= 1'b0;
            e1_code  <= '0;
        end else begin
            tog_q1 <= ps2_key[10];
            tog_q2 <= tog_q1;
            e1_vld <= evt;
            if (evt) begin
                e1_press <= ps2_key[9];
                e1_code  <= ps2_key[8:0];
            end
        end
    end

    // Only a change of the scancode's up/down state counts; typematic repeats fall out here.
    assign e1_take = e1_vld && (key_bmp[e1_code] != e1_press);
    assign e1_hit  = e1_take && map_rd[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            key_bmp <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cnt[r][c] <= 2'd0;
        end else if (e1_take) begin
            key_bmp[e1_code] <= e1_press;
            // Out-of-range row/column indices never match a loop index, so they touch no counter.
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (e1_hit && map_rd[5:3] == 3'(r) && map_rd[2:0] == 3'(c)) begin
                        if (e1_press && cnt[r][c] != 2'd3)
                            cnt[r][c] <= cnt[r][c] + 2'd1;
                        else if (!e1_press && cnt[r][c] != 2'd0)
                            cnt[r][c] <= cnt[r][c] - 2'd1;
                    end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hold      <= '0;
            inj_pos_q <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            if (inj_valid && inj_ready)
                inj_pos_q <= inj_pos;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        inj_ready = 1'b0;
        inj_on    = 1'b0;
        case (state)
            S_IDLE: begin
                inj_ready = 1'b1;
                if (inj_valid) begin
                    state_nxt = S_PRESS;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            S_PRESS: begin
                inj_on = 1'b1;
                if (hold == 16'd0) begin
                    state_nxt = S_GAP;
                    hold_nxt  = HOLD_LOAD;
                end else begin
                    hold_nxt = hold - 16'd1;
                end
            end
            S_GAP: begin
                if (hold == 16'd0)
                    state_nxt = S_IDLE;
                else
                    hold_nxt = hold - 16'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        kbus_nxt = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!row[r] && (cnt[r][c] != 2'd0 ||
                    (inj_on && inj_pos_q[5:3] == 3'(r) && inj_pos_q[2:0] == 3'(c))))
                    kbus_nxt[c] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            kbus <= '1;
        else
            kbus <= kbus_nxt;
    end
endmodule

// File: tb/tb_kbd_matrix_gen.sv
// Randomized bench for kbd_matrix_gen: an 8x8 and a 6x6 instance share stimulus and are checked against a key-level model.
module tb_kbd_matrix_gen;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  row;
    logic [7:0]  kbus_a;
    logic [5:0]  kbus_b;
    logic        map_we;
    logic [8:0]  map_addr;
    logic [7:0]  map_data;
    logic        inj_valid;
    logic [5:0]  inj_pos;
    logic        rdy_a, rdy_b;

    always #5 clk = ~clk;

    kbd_matrix_gen #(.ROWS(8), .COLS(8), .INJ_HOLD(H)) dut_a (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .row(row), .kbus(kbus_a),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .inj_valid(inj_valid), .inj_pos(inj_pos), .inj_ready(rdy_a));

    kbd_matrix_gen #(.ROWS(6), .COLS(6), .INJ_HOLD(H)) dut_b (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .row(row[5:0]), .kbus(kbus_b),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .inj_valid(inj_valid), .inj_pos(inj_pos), .inj_ready(rdy_b));

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mmap [512];
    bit         bmp  [512];
    int         cnt  [2][8][8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_kbus(int m, logic [7:0] rw, bit inj_on, logic [5:0] ipos);
        int nr = (m == 0) ? 8 : 6;
        logic [7:0] res = 8'hFF;
        for (int c = 0; c < nr; c++)
            for (int r = 0; r < nr; r++)
                if (!rw[r] && (cnt[m][r][c] != 0 ||
                    (inj_on && int'(ipos[5:3]) == r && int'(ipos[2:0]) == c)))
                    res[c] = 1'b0;
        return res;
    endfunction

    task automatic check_both(input string tag, input bit inj_on, input logic [5:0] ipos);
        check(tag, {24'd0, kbus_a}, {24'd0, model_kbus(0, row, inj_on, ipos)});
        check($sformatf("%s_b", tag), {24'd0, 2'b11, kbus_b}, {24'd0, model_kbus(1, row, inj_on, ipos)});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) bmp[i] = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) cnt[m][r][c] = 0;
    endtask

    task automatic model_event(input bit press, input logic [8:0] code);
        logic [7:0] e = mmap[code];
        int r = int'(e[5:3]);
        int c = int'(e[2:0]);
        if (bmp[code] == press) return;
        bmp[code] = press;
        if (!e[7]) return;
        for (int m = 0; m < 2; m++) begin
            int lim = (m == 0) ? 8 : 6;
            if (r < lim && c < lim) begin
                if (press && cnt[m][r][c] < 3) cnt[m][r][c]++;
                if (!press && cnt[m][r][c] > 0) cnt[m][r][c]--;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_map(input logic [8:0] a, input logic [7:0] d);
        map_we = 1'b1; map_addr = a; map_data = d;
        tick(1);
        map_we = 1'b0;
        mmap[a] = d;
    endtask

    task automatic set_row(input logic [7:0] v);
        row = v;
        tick(1);
        check_both("row_latency", 1'b0, 6'd0);
    endtask

    // Optionally rewrites the same scancode's entry during the lookup cycle.
    task automatic send_key(input bit press, input logic [8:0] code, input bit do_wr, input logic [7:0] wr_data);
        ps2_key = {~ps2_key[10], press, code};
        if (do_wr) begin
            tick(1);
            map_we = 1'b1; map_addr = code; map_data = wr_data;
            tick(1);
            map_we = 1'b0;
            tick(2);
        end else begin
            tick(4);
        end
        model_event(press, code);
        if (do_wr) mmap[code] = wr_data;
        check_both("key_event", 1'b0, 6'd0);
        tick(2);
    endtask

    task automatic inject(input logic [5:0] pos, input logic [7:0] rw);
        int guard = 0;
        while (!rdy_a && guard < 100) begin tick(1); guard++; end
        check("inj_wait_ready", {31'd0, rdy_a}, 32'd1);
        row = rw; inj_pos = pos; inj_valid = 1'b1;
        tick(1);
        inj_pos = ~pos;
        for (int k = 0; k <= 2 * H; k++) begin
            check("inj_ready", {31'd0, rdy_a}, {31'd0, k >= 2 * H});
            check("inj_ready_b", {31'd0, rdy_b}, {31'd0, k >= 2 * H});
            check_both("inj_kbus", (k >= 1 && k <= H), pos);
            if (k == 2 * H - 1) inj_valid = 1'b0;
            if (k < 2 * H) tick(1);
        end
    endtask

    initial begin
        reset = 1'b1; ps2_key = 11'h400; row = 8'hFF; map_we = 1'b0; map_addr = '0;
        map_data = '0; inj_valid = 1'b0; inj_pos = '0;
        model_clear();
        tick(3);
        reset = 1'b0;
        check("reset_kbus", {24'd0, kbus_a}, 32'hFF);
        check("reset_kbus_b", {26'd0, kbus_b}, 32'h3F);
        check("reset_ready", {31'd0, rdy_a}, 32'd1);

        for (int a = 0; a < 512; a++) write_map(9'(a), 8'h00);
        tick(2);
        check_both("idle_after_clear", 1'b0, 6'd0);

        write_map(9'h01C, 8'h8A);
        set_row(8'hFD);
        send_key(1'b1, 9'h01C, 1'b0, 8'h00);
        check("make_1c", {24'd0, kbus_a}, 32'hFB);
        send_key(1'b0, 9'h01C, 1'b0, 8'h00);
        check("break_1c", {24'd0, kbus_a}, 32'hFF);

        write_map(9'h012, 8'h8F);
        write_map(9'h059, 8'h8F);
        send_key(1'b1, 9'h012, 1'b0, 8'h00);
        send_key(1'b1, 9'h059, 1'b0, 8'h00);
        send_key(1'b0, 9'h012, 1'b0, 8'h00);
        check("shared_pos_held", {31'd0, kbus_a[7]}, 32'd0);
        send_key(1'b0, 9'h059, 1'b0, 8'h00);
        check("shared_pos_free", {24'd0, kbus_a}, 32'hFF);

        for (int i = 0; i < 3; i++) send_key(1'b1, 9'h01C, 1'b0, 8'h00);
        send_key(1'b0, 9'h01C, 1'b0, 8'h00);
        check("repeat_discard", {24'd0, kbus_a}, 32'hFF);

        inject(6'o17, 8'hFD);
        for (int i = 0; i < 4; i++) inject(6'($urandom_range(0, 63)), 8'($urandom));

        row = 8'hFD;
        send_key(1'b1, 9'h01C, 1'b1, 8'h9B);
        check("wr_collide_old", {24'd0, kbus_a}, 32'hFB);
        send_key(1'b0, 9'h01C, 1'b0, 8'h00);
        check("wr_collide_new", {24'd0, kbus_a}, 32'hFB);

        for (int i = 0; i < 300; i++) begin
            logic [8:0] code = 9'($urandom_range(9'h080, 9'h08F));
            int act = $urandom_range(0, 9);
            if (act == 0)
                write_map(code, 8'($urandom));
            else if (act == 1)
                set_row(8'($urandom));
            else
                send_key(1'($urandom), code, ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        for (int i = 0; i < 6; i++) send_key(1'b1, 9'h080 + 9'(i), 1'b0, 8'h00);
        row = 8'hFD; inj_pos = 6'o17; inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        ps2_key[10] = ~ps2_key[10];
        tick(1);
        reset = 1'b0;
        model_clear();
        check("midpress_reset", {24'd0, kbus_a}, 32'hFF);
        check("midpress_ready", {31'd0, rdy_a}, 32'd1);
        tick(4);
        check_both("no_spurious_evt", 1'b0, 6'd0);
        row = 8'hF7;
        send_key(1'b1, 9'h01C, 1'b0, 8'h00);
        check("map_kept", {24'd0, kbus_a}, 32'hF7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
